// File: rtl/matmul_seq.sv
// Sequential NxN signed fixed-point matrix multiplier: one multiply-accumulate per cycle,
// with a valid/ready handshake on both the operand side and the result side.
module matmul_seq #(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 3,
    parameter int SATURATE    = 1
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   matrix_a,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   matrix_b,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   result,
    output logic                                            overflow
);

    localparam int N      = MATRIX_SIZE;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = 2 * DATA_WIDTH + $clog2(N) + 1;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    localparam logic signed [ACC_W-1:0] ELEM_MAX =
        {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ELEM_MIN = ~ELEM_MAX;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [DATA_WIDTH-1:0] a_mat   [N][N];
    logic signed [DATA_WIDTH-1:0] b_mat   [N][N];
    logic signed [DATA_WIDTH-1:0] res_mat [N][N];

    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] c_idx;
    logic [IDX_W-1:0] k_idx;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod;

    logic                  accept;
    logic                  k_last;
    logic                  elem_last;
    logic [DATA_WIDTH:0]   fit_out;
    logic [DATA_WIDTH-1:0] elem;
    logic                  elem_ovf;

    // Returns {overflow, element}: clamps or wraps a shifted sum into DATA_WIDTH bits.
    function automatic logic [DATA_WIDTH:0] fit_elem(input logic signed [ACC_W-1:0] v);
        logic [DATA_WIDTH:0] f;
        if (v > ELEM_MAX) begin
            f = {1'b1, (SATURATE != 0) ? ELEM_MAX[DATA_WIDTH-1:0] : v[DATA_WIDTH-1:0]};
        end else if (v < ELEM_MIN) begin
            f = {1'b1, (SATURATE != 0) ? ELEM_MIN[DATA_WIDTH-1:0] : v[DATA_WIDTH-1:0]};
        end else begin
            f = {1'b0, v[DATA_WIDTH-1:0]};
        end
        return f;
    endfunction

    assign accept    = in_ready && in_valid;
    assign k_last    = (k_idx == LAST);
    assign elem_last = k_last && (c_idx == LAST) && (r_idx == LAST);

    assign a_ext   = PROD_W'(a_mat[r_idx][k_idx]);
    assign b_ext   = PROD_W'(b_mat[k_idx][c_idx]);
    assign prod    = a_ext * b_ext;
    assign acc_sum = acc + ACC_W'(prod);
    // Arithmetic shift floors toward negative infinity.
    assign shifted = acc_sum >>> BIN_POS;
    assign fit_out = fit_elem(shifted);
    assign elem     = fit_out[DATA_WIDTH-1:0];
    assign elem_ovf = fit_out[DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (elem_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand snapshot: later input changes cannot disturb the running product.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_mat[i][j] <= matrix_a[(i*N+j)*DATA_WIDTH +: DATA_WIDTH];
                    b_mat[i][j] <= matrix_b[(i*N+j)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            r_idx    <= '0;
            c_idx    <= '0;
            k_idx    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    res_mat[i][j] <= '0;
                end
            end
        end else if (accept) begin
            acc      <= '0;
            r_idx    <= '0;
            c_idx    <= '0;
            k_idx    <= '0;
            overflow <= 1'b0;
        end else if (state == COMPUTE) begin
            if (k_last) begin
                acc                   <= '0;
                res_mat[r_idx][c_idx] <= elem;
                overflow              <= overflow | elem_ovf;
                k_idx                 <= '0;
                if (c_idx == LAST) begin
                    c_idx <= '0;
                    r_idx <= (r_idx == LAST) ? '0 : r_idx + ONE;
                end else begin
                    c_idx <= c_idx + ONE;
                end
            end else begin
                acc   <= acc_sum;
                k_idx <= k_idx + ONE;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign result[(gi*N+gj)*DATA_WIDTH +: DATA_WIDTH] = res_mat[gi][gj];
        end
    end

endmodule

// File: tb/tb_matmul_seq.sv
// Directed and randomized checks of matmul_seq for N=1,2,3 and both overflow modes,
// compared against a plain-arithmetic fixed-point matrix product model.
module tb_matmul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic         iv3, ir3, ov3, or3, of3;
    logic [143:0] ma3, mb3, res3;
    logic         iv2, or2, ir2s, ov2s, of2s, ir2w, ov2w, of2w;
    logic [63:0]  ma2, mb2, res2s, res2w;
    logic         iv1, ir1, ov1, or1, of1;
    logic [15:0]  ma1, mb1, res1;

    int           a [9];
    int           b [9];
    logic [143:0] exp_res;
    logic         exp_ovf;
    int           lat;
    int           gap;
    logic [143:0] p;
    logic [143:0] q;

    matmul_seq #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(3), .SATURATE(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .matrix_a(ma3), .matrix_b(mb3),
        .out_valid(ov3), .out_ready(or3), .result(res3), .overflow(of3));

    matmul_seq #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(2), .SATURATE(1)) dut2s (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2s), .matrix_a(ma2), .matrix_b(mb2),
        .out_valid(ov2s), .out_ready(or2), .result(res2s), .overflow(of2s));

    matmul_seq #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(2), .SATURATE(0)) dut2w (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2w), .matrix_a(ma2), .matrix_b(mb2),
        .out_valid(ov2w), .out_ready(or2), .result(res2w), .overflow(of2w));

    matmul_seq #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(1), .SATURATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .matrix_a(ma1), .matrix_b(mb1),
        .out_valid(ov1), .out_ready(or1), .result(res1), .overflow(of1));

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [143:0] pack(input int n, input int m[9]);
        logic [143:0] r;
        r = '0;
        for (int i = 0; i < n * n; i++) r[i*16 +: 16] = m[i][15:0];
        return r;
    endfunction

    // C = (A*B) >>> 8 per element, then clamp or wrap into 16 signed bits.
    function automatic void model(input int n, input bit sat, input int ma[9], input int mb[9],
                                  output logic [143:0] res, output logic ovf);
        longint      s;
        logic [15:0] e;
        res = '0;
        ovf = 1'b0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int k = 0; k < n; k++) s += longint'(ma[r*n+k]) * longint'(mb[k*n+c]);
                s = s >>> 8;
                if (s > 32767) begin
                    ovf = 1'b1;
                    e = sat ? 16'h7FFF : s[15:0];
                end else if (s < -32768) begin
                    ovf = 1'b1;
                    e = sat ? 16'h8000 : s[15:0];
                end else begin
                    e = s[15:0];
                end
                res[(r*n+c)*16 +: 16] = e;
            end
        end
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < 9; i++) begin
            a[i] = int'($urandom_range(5118)) - 2559;
            b[i] = int'($urandom_range(5118)) - 2559;
        end
    endtask

    task automatic go3();
        logic [143:0] pa, pb;
        pa = pack(3, a);
        pb = pack(3, b);
        @(negedge clk);
        ma3 = pa; mb3 = pb; iv3 = 1'b1;
        @(posedge clk); #1;
        iv3 = 1'b0; ma3 = ~pa; mb3 = ~pb;
    endtask

    task automatic go2();
        logic [143:0] pa, pb;
        pa = pack(2, a);
        pb = pack(2, b);
        @(negedge clk);
        ma2 = pa[63:0]; mb2 = pb[63:0]; iv2 = 1'b1;
        @(posedge clk); #1;
        iv2 = 1'b0; ma2 = ~ma2; mb2 = ~mb2;
    endtask

    task automatic go1();
        logic [143:0] pa, pb;
        pa = pack(1, a);
        pb = pack(1, b);
        @(negedge clk);
        ma1 = pa[15:0]; mb1 = pb[15:0]; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0; ma1 = ~ma1; mb1 = ~mb1;
    endtask

    task automatic wait3(output int n);
        n = 0;
        while (ov3 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait2(output int n);
        n = 0;
        while (ov2s !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait1(output int n);
        n = 0;
        while (ov1 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    endtask

    task automatic rel3();
        @(negedge clk); or3 = 1'b1;
        @(posedge clk); #1; or3 = 1'b0;
    endtask

    task automatic rel2();
        @(negedge clk); or2 = 1'b1;
        @(posedge clk); #1; or2 = 1'b0;
    endtask

    task automatic rel1();
        @(negedge clk); or1 = 1'b1;
        @(posedge clk); #1; or1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        iv3 = 0; or3 = 0; ma3 = '0; mb3 = '0;
        iv2 = 0; or2 = 0; ma2 = '0; mb2 = '0;
        iv1 = 0; or1 = 0; ma1 = '0; mb1 = '0;

        // asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst in_ready", 144'(ir3), 144'(1));
        chk("rst out_valid", 144'(ov3), 144'(0));
        chk("rst result", res3, 144'(0));
        chk("rst overflow", 144'(of3), 144'(0));
        chk("rst n1 in_ready", 144'(ir1), 144'(1));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // identity, N=2
        a = '{256, 0, 0, 256, 0, 0, 0, 0, 0};
        b = '{384, -256, 64, 512, 0, 0, 0, 0, 0};
        go2();
        wait2(lat);
        chk("id2 latency", 144'(lat), 144'(8));
        chk("id2 sat result", 144'(res2s), 144'(64'h0200_0040_FF00_0180));
        chk("id2 wrap result", 144'(res2w), 144'(64'h0200_0040_FF00_0180));
        chk("id2 wrap valid", 144'(ov2w), 144'(1));
        chk("id2 overflow", 144'(of2s), 144'(0));
        rel2();
        chk("id2 back idle valid", 144'(ov2s), 144'(0));
        chk("id2 back idle ready", 144'(ir2s), 144'(1));

        // overflow in both modes, N=2
        for (int i = 0; i < 4; i++) begin a[i] = 32512; b[i] = 32512; end
        go2();
        wait2(lat);
        chk("ovf latency", 144'(lat), 144'(8));
        chk("ovf sat result", 144'(res2s), 144'({4{16'h7FFF}}));
        chk("ovf sat flag", 144'(of2s), 144'(1));
        chk("ovf wrap result", 144'(res2w), 144'({4{16'h0200}}));
        chk("ovf wrap flag", 144'(of2w), 144'(1));
        rel2();
        chk("ovf retained result", 144'(res2s), 144'({4{16'h7FFF}}));
        chk("ovf retained flag", 144'(of2s), 144'(1));
        a = '{256, 0, 0, 256, 0, 0, 0, 0, 0};
        b = '{-1, 32767, -32768, 5, 0, 0, 0, 0, 0};
        go2();
        chk("ovf cleared on accept", 144'(of2s), 144'(0));
        wait2(lat);
        chk("id2b result", 144'(res2w), 144'(64'h0005_8000_7FFF_FFFF));
        chk("id2b overflow", 144'(of2w), 144'(0));
        rel2();

        // signed products, N=1
        a[0] = -384; b[0] = 512;
        go1();
        wait1(lat);
        chk("n1 latency", 144'(lat), 144'(1));
        chk("n1 neg product", 144'(res1), 144'(16'hFD00));
        chk("n1 overflow", 144'(of1), 144'(0));
        rel1();
        a[0] = -1; b[0] = 128;
        go1();
        wait1(lat);
        chk("n1 floor result", 144'(res1), 144'(16'hFFFF));
        rel1();

        // backpressure in DONE, N=3
        rand_ops();
        model(3, 1'b1, a, b, exp_res, exp_ovf);
        go3();
        wait3(lat);
        chk("bp latency", 144'(lat), 144'(27));
        chk("bp result", res3, exp_res);
        @(negedge clk); iv3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp hold valid", 144'(ov3), 144'(1));
            chk("bp hold result", res3, exp_res);
            chk("bp hold overflow", 144'(of3), 144'(exp_ovf));
            chk("bp hold ready", 144'(ir3), 144'(0));
        end
        @(negedge clk); or3 = 1'b1; iv3 = 1'b0;
        @(posedge clk); #1; or3 = 1'b0;
        chk("bp release valid", 144'(ov3), 144'(0));
        chk("bp release ready", 144'(ir3), 144'(1));
        chk("bp retained result", res3, exp_res);

        // reset in the middle of a product
        rand_ops();
        go3();
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst valid", 144'(ov3), 144'(0));
        chk("midrst result", res3, 144'(0));
        chk("midrst ready", 144'(ir3), 144'(1));
        chk("midrst overflow", 144'(of3), 144'(0));
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        a = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
        for (int i = 0; i < 9; i++) b[i] = int'($urandom_range(5118)) - 2559;
        go3();
        wait3(lat);
        chk("id3 latency", 144'(lat), 144'(27));
        chk("id3 result", res3, pack(3, b));
        chk("id3 overflow", 144'(of3), 144'(0));
        rel3();

        // back-to-back random products with handshakes held high
        iv3 = 1'b1;
        or3 = 1'b1;
        for (int t = 0; t < 20; t++) begin
            rand_ops();
            model(3, 1'b1, a, b, exp_res, exp_ovf);
            p = pack(3, a);
            q = pack(3, b);
            @(negedge clk);
            ma3 = p; mb3 = q;
            gap = 0;
            while (ir3 !== 1'b1 && gap < 50) begin @(negedge clk); gap++; end
            chk("b2b idle gap", 144'(gap), 144'((t == 0) ? 0 : 1));
            @(posedge clk); #1;
            ma3 = ~p; mb3 = ~q;
            wait3(lat);
            chk("b2b latency", 144'(lat), 144'(27));
            chk("b2b result", res3, exp_res);
            chk("b2b overflow", 144'(of3), 144'(exp_ovf));
        end
        iv3 = 1'b0;
        @(posedge clk); #1;
        or3 = 1'b0;
        chk("final idle ready", 144'(ir3), 144'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
